dma_channel: RTL and testbench
==============================

Name: dma_channel

Overview:
- Single-channel DMA transfer engine sitting directly upstream of the IO peripheral and beside main memory on the shared bus.
- Arbitrates for the bus (hrq/hlda), then sequences the peripheral strobes (ior/iow) and memory strobes (memr/memw).
- Tracks current address and remaining count and moves bytes between the peripheral and memory through an internal temp register.
- Signals terminal count on the last transfer.

Parameters:
- ADDR_W, 16, width of the address bus and of the address/count registers.
- DATA_W, 8, width of the data bus and temp register.
- BURST, 1; 1 = hold the bus until tc; 0 = release the bus after every byte and re-arbitrate.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_we  in  1  load the configuration registers; ignored while busy.
- cfg_base  in  ADDR_W  starting memory address.
- cfg_count  in  ADDR_W  transfers minus one.
- cfg_dir  in  1  direction: 0 = peripheral->memory (IO read), 1 = memory->peripheral (IO write).
- cfg_autoinit  in  1  reload base/count at tc and stay armed.
- dreq  in  1  transfer request from the peripheral.
- hrq  out  1  bus request to the CPU.
- hlda  in  1  bus grant from the CPU.
- dack  out  1  acknowledge to the peripheral; high in every bus-owning state.
- ior, iow  out  1  peripheral read/write strobes.
- memr, memw  out  1  memory read/write strobes.
- aen  out  2  bus-owner code: 00 = CPU, 01 = DMA drives address and data, 10 = DMA drives data only, 11 = peripheral drives data.
- io_ready  in  1  peripheral ready.
- mem_ready  in  1  memory ready; this same net feeds the peripheral's READY_MEM.
- data  inout  DATA_W  driven with tmp when aen is 01 (memory write) or 10; otherwise Z.
- address  inout  ADDR_W  driven with cur_addr when aen=01; otherwise Z.
- tc  out  1  one-cycle pulse on completion of the last transfer.
- busy  out  1  armed: configured and not yet finished.

Behaviour:
- Reset (asynchronous, any state): state=IDLE. All strobes, hrq, dack and tc are 0; aen=00; busy=0; data and address are Z. cur_addr, cur_count and tmp are cleared.
- cfg_we while idle: loads base and count into both the shadow registers and cur_addr/cur_count; busy=1.
- Registered outputs: all outputs come from registers, with no combinational path from inputs to outputs; bus drivers decode from registered aen.
- IDLE: if busy && dreq, go to REQ with hrq=1.
- REQ: wait for hlda, then branch on cfg_dir. dreq low before grant -> return to IDLE with hrq=0.
- Peripheral->memory path:
  - IO_RD: ior=1, aen=11. Wait io_ready, then latch data into tmp. Go to MEM_WR.
  - MEM_WR: ior stays 1, memw=1, aen=01, drive address and data. Wait mem_ready (the peripheral advances its pointer on this). Go to NEXT.
- Memory->peripheral path:
  - MEM_RD: memr=1, aen=01, address driven, data Z. On mem_ready, latch data into tmp. Go to IO_WR.
  - IO_WR: iow=1, aen=10, drive tmp. Wait io_ready high, then go to IO_WR2.
  - IO_WR2: hold iow and data for one more cycle, because the peripheral samples the byte on its second IOW cycle. Go to NEXT.
- NEXT: drop all strobes.
  - cur_addr+1, wrapping FFFF->0000.
  - cur_count==0: tc=1 for this cycle. If autoinit, reload from the shadow registers and stay busy; otherwise busy=0. Release hrq/aen/dack and go to IDLE.
  - Otherwise cur_count-1. If BURST && dreq, loop to the transfer state for cfg_dir. Else release the bus and go to IDLE.
- hlda dropped mid-transfer: finish the current byte, then release the bus and go to IDLE; the transfer does not advance early.
- Simultaneous cfg_we with busy=1: ignored.
- Timing: a byte takes ≥2 cycles for IO read and ≥3 cycles for IO write, plus wait states.

Decomposition:
- Shared package, dma_pkg:
  - state encoding;
  - aen codes AEN_CPU, AEN_DMA_AD, AEN_DMA_D, AEN_IO;
  - direction constants DIR_IO2MEM, DIR_MEM2IO.
- Sub-module dma_addr_cnt: holds the shadow and current address/count registers, with load, step and reload controls and a last flag (count==0).
- dma_channel holds the FSM, strobes and bus drivers.

Test Plan:
- IO->mem, base=0x0100, count=3, BURST=1, peripheral preloaded with 0..15, memory zero-wait -> mem[0x0100..0x0103]=0,1,2,3; tc pulses once after the 4th memw; busy falls; aen=00.
- Mem->IO, base=0x0200, count=1, mem[0x0200]=0xA5, mem[0x0201]=0x5A -> peripheral slots 0,1 hold A5,5A; each iow is high ≥3 cycles; data is driven only while aen=10.
- Wrap: base=0xFFFF, count=1 -> second access at address 0x0000.
- Autoinit: base=0x0010, count=0, autoinit=1, dreq held -> tc every transfer; every access at 0x0010; busy stays 1.
- Wait states: mem_ready delayed 3 cycles -> memw and address held stable; no extra increment.
- Reset asserted during MEM_WR -> all outputs 0 and data/address Z immediately (before the next clk edge); busy=0.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared definitions for the single-channel DMA engine: FSM states, bus-owner
// codes and transfer-direction constants.
package dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_IO_RD,
    ST_MEM_WR,
    ST_MEM_RD,
    ST_IO_WR,
    ST_IO_WR2,
    ST_NEXT
  } state_t;

  typedef enum logic [1:0] {
    AEN_CPU    = 2'b00,
    AEN_DMA_AD = 2'b01,
    AEN_DMA_D  = 2'b10,
    AEN_IO     = 2'b11
  } aen_t;

  localparam logic DIR_IO2MEM = 1'b0;
  localparam logic DIR_MEM2IO = 1'b1;

  // First bus-owning state of a byte for the given direction.
  function automatic state_t xfer_state(input logic dir);
    return (dir == DIR_MEM2IO) ? ST_MEM_RD : ST_IO_RD;
  endfunction

endpackage

// File: rtl/dma_channel_if.sv
// Control, handshake and strobe signals between the DMA channel and its
// surroundings (CPU arbiter, peripheral, memory, configuration).
interface dma_channel_if #(
  parameter int ADDR_W = 16
) ();

  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_base;
  logic [ADDR_W-1:0] cfg_count;
  logic              cfg_dir;
  logic              cfg_autoinit;
  logic              dreq;
  logic              hrq;
  logic              hlda;
  logic              dack;
  logic              ior;
  logic              iow;
  logic              memr;
  logic              memw;
  dma_pkg::aen_t     aen;
  logic              io_ready;
  logic              mem_ready;
  logic              tc;
  logic              busy;

  modport master (
    input  cfg_we, cfg_base, cfg_count, cfg_dir, cfg_autoinit,
    input  dreq, hlda, io_ready, mem_ready,
    output hrq, dack, ior, iow, memr, memw, aen, tc, busy
  );

  modport slave (
    output cfg_we, cfg_base, cfg_count, cfg_dir, cfg_autoinit,
    output dreq, hlda, io_ready, mem_ready,
    input  hrq, dack, ior, iow, memr, memw, aen, tc, busy
  );

endinterface

// File: rtl/dma_addr_cnt.sv
// Shadow and current address/count registers. Step advances the address and
// counts down (count sticks at zero); reload restores the shadow values.
module dma_addr_cnt #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] count,
  input  logic              step,
  input  logic              reload,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              last
);

  logic [ADDR_W-1:0] base_reg;
  logic [ADDR_W-1:0] count_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_reg  <= '0;
      count_reg <= '0;
      addr_reg  <= '0;
      cnt_reg   <= '0;
    end else if (load) begin
      base_reg  <= base;
      count_reg <= count;
      addr_reg  <= base;
      cnt_reg   <= count;
    end else if (reload) begin
      addr_reg <= base_reg;
      cnt_reg  <= count_reg;
    end else if (step) begin
      addr_reg <= addr_reg + ADDR_W'(1);
      if (cnt_reg != '0) begin
        cnt_reg <= cnt_reg - ADDR_W'(1);
      end
    end
  end

  assign cur_addr = addr_reg;
  assign last     = (cnt_reg == '0);

endmodule

// File: rtl/dma_channel.sv
// Single-channel DMA engine: bus arbitration, strobe sequencing and the shared
// data/address bus drivers. Every output is a register or a decode of one.
module dma_channel
  import dma_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int BURST  = 1
) (
  input  logic             clk,
  input  logic             rst,
  dma_channel_if.master    bus,
  inout  wire [DATA_W-1:0] data,
  inout  wire [ADDR_W-1:0] address
);

  state_t            state_reg, state_next;
  aen_t              aen_reg, aen_next;
  logic              hrq_reg, hrq_next;
  logic              dack_reg, dack_next;
  logic              ior_reg, ior_next;
  logic              iow_reg, iow_next;
  logic              memr_reg, memr_next;
  logic              memw_reg, memw_next;
  logic              tc_reg, tc_next;
  logic              busy_reg, busy_next;
  logic              dir_reg;
  logic              autoinit_reg;
  logic [DATA_W-1:0] tmp_reg;
  logic              cfg_load, step, reload, latch_tmp, last;
  logic [ADDR_W-1:0] cur_addr;
  logic              data_oe, addr_oe;

  assign cfg_load = bus.cfg_we && !busy_reg;

  dma_addr_cnt #(.ADDR_W(ADDR_W)) u_addr_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cfg_load),
    .base     (bus.cfg_base),
    .count    (bus.cfg_count),
    .step     (step),
    .reload   (reload),
    .cur_addr (cur_addr),
    .last     (last)
  );

  always_comb begin
    state_next = state_reg;
    busy_next  = busy_reg || cfg_load;
    step       = 1'b0;
    reload     = 1'b0;
    latch_tmp  = 1'b0;
    case (state_reg)
      ST_IDLE:   if (busy_reg && bus.dreq) state_next = ST_REQ;
      ST_REQ: begin
        if (bus.hlda)       state_next = xfer_state(dir_reg);
        else if (!bus.dreq) state_next = ST_IDLE;
      end
      ST_IO_RD: begin
        if (bus.io_ready) begin
          latch_tmp  = 1'b1;
          state_next = ST_MEM_WR;
        end
      end
      ST_MEM_WR: if (bus.mem_ready) state_next = ST_NEXT;
      ST_MEM_RD: begin
        if (bus.mem_ready) begin
          latch_tmp  = 1'b1;
          state_next = ST_IO_WR;
        end
      end
      ST_IO_WR:  if (bus.io_ready) state_next = ST_IO_WR2;
      ST_IO_WR2: state_next = ST_NEXT;
      ST_NEXT: begin
        step = 1'b1;
        if (last) begin
          if (autoinit_reg) reload = 1'b1;
          else              busy_next = 1'b0;
          state_next = ST_IDLE;
        end else if (BURST != 0 && bus.dreq && bus.hlda) begin
          state_next = xfer_state(dir_reg);
        end else begin
          state_next = ST_IDLE;
        end
      end
      default:   state_next = ST_IDLE;
    endcase

    // Outputs are decoded from the state being entered and then registered.
    hrq_next  = (state_next != ST_IDLE);
    dack_next = (state_next != ST_IDLE) && (state_next != ST_REQ);
    ior_next  = (state_next == ST_IO_RD) || (state_next == ST_MEM_WR);
    memw_next = (state_next == ST_MEM_WR);
    memr_next = (state_next == ST_MEM_RD);
    iow_next  = (state_next == ST_IO_WR) || (state_next == ST_IO_WR2);
    tc_next   = (state_next == ST_NEXT) && last;
    case (state_next)
      ST_IO_RD:                       aen_next = AEN_IO;
      ST_MEM_WR, ST_MEM_RD, ST_NEXT:  aen_next = AEN_DMA_AD;
      ST_IO_WR, ST_IO_WR2:            aen_next = AEN_DMA_D;
      default:                        aen_next = AEN_CPU;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      aen_reg      <= AEN_CPU;
      hrq_reg      <= 1'b0;
      dack_reg     <= 1'b0;
      ior_reg      <= 1'b0;
      iow_reg      <= 1'b0;
      memr_reg     <= 1'b0;
      memw_reg     <= 1'b0;
      tc_reg       <= 1'b0;
      busy_reg     <= 1'b0;
      dir_reg      <= DIR_IO2MEM;
      autoinit_reg <= 1'b0;
      tmp_reg      <= '0;
    end else begin
      state_reg <= state_next;
      aen_reg   <= aen_next;
      hrq_reg   <= hrq_next;
      dack_reg  <= dack_next;
      ior_reg   <= ior_next;
      iow_reg   <= iow_next;
      memr_reg  <= memr_next;
      memw_reg  <= memw_next;
      tc_reg    <= tc_next;
      busy_reg  <= busy_next;
      if (cfg_load) begin
        dir_reg      <= bus.cfg_dir;
        autoinit_reg <= bus.cfg_autoinit;
      end
      if (latch_tmp) tmp_reg <= data;
    end
  end

  assign bus.hrq  = hrq_reg;
  assign bus.dack = dack_reg;
  assign bus.ior  = ior_reg;
  assign bus.iow  = iow_reg;
  assign bus.memr = memr_reg;
  assign bus.memw = memw_reg;
  assign bus.aen  = aen_reg;
  assign bus.tc   = tc_reg;
  assign bus.busy = busy_reg;

  // During a memory read aen is 01 but the memory owns the data lines.
  assign addr_oe = (aen_reg == AEN_DMA_AD);
  assign data_oe = (aen_reg == AEN_DMA_D) || ((aen_reg == AEN_DMA_AD) && memw_reg);
  assign data    = data_oe ? tmp_reg  : 'z;
  assign address = addr_oe ? cur_addr : 'z;

endmodule

// File: tb/tb_dma_channel.sv
// Randomized self-checking bench for dma_channel: bus-level memory/peripheral
// models, a transfer log, and expectations computed from base/count arithmetic.
module tb_dma_channel;
  import dma_pkg::*;

  localparam int AW = 16;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dma_channel_if #(.ADDR_W(AW)) bus ();
  wire [DW-1:0] data_bus;
  wire [AW-1:0] addr_bus;

  dma_channel #(.ADDR_W(AW), .DATA_W(DW), .BURST(1)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .data    (data_bus),
    .address (addr_bus)
  );

  // Memory read contents and peripheral source bytes (written only at start).
  logic [7:0] rom    [0:65535];
  logic [7:0] periph [0:255];

  // Monitor state (written only by the negedge bus model).
  logic [7:0]  pptr = 8'd0;
  int          mem_cnt = 0, io_cnt = 0;
  int          tc_cnt = 0, tc_wr = 0, addr_viol = 0, data_viol = 0, iow_len = 0;
  logic        memw_prev = 1'b0;
  logic [AW-1:0] memw_addr = '0;
  logic [7:0]  iow_last = 8'd0;
  logic [AW-1:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  logic [7:0]  iow_q[$];
  int          iow_len_q[$];

  // Stimulus knobs (written only by the initial block).
  int mem_delay = 0, io_delay = 1;
  bit drop_en = 1'b0, dreq_en = 1'b0, dreq_rand = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  logic mem_drive, per_drive;
  assign mem_drive = bus.memr && (bus.aen == AEN_DMA_AD);
  assign per_drive = bus.ior && (bus.aen == AEN_IO);
  assign data_bus  = mem_drive ? rom[addr_bus] : 'z;
  assign data_bus  = per_drive ? periph[pptr]  : 'z;

  // Bus partners: arbiter, memory, peripheral, plus the transfer log.
  always @(negedge clk) begin
    if (bus.memr || bus.memw) begin
      bus.mem_ready = (mem_cnt >= mem_delay);
      mem_cnt++;
    end else begin
      bus.mem_ready = 1'b0;
      mem_cnt = 0;
    end
    if (bus.ior || bus.iow) begin
      bus.io_ready = (io_cnt >= io_delay);
      io_cnt++;
    end else begin
      bus.io_ready = 1'b0;
      io_cnt = 0;
    end
    if (!bus.hrq)      bus.hlda = 1'b0;
    else if (!bus.hlda) bus.hlda = ($urandom_range(0, 1) == 0);
    else if (drop_en && $urandom_range(0, 15) == 0) bus.hlda = 1'b0;
    bus.dreq = dreq_en && (!dreq_rand || $urandom_range(0, 3) != 0);

    if (bus.memw && bus.aen == AEN_DMA_AD) begin
      if (memw_prev && addr_bus != memw_addr) addr_viol++;
      memw_addr = addr_bus;
      if (bus.mem_ready) begin
        wr_addr_q.push_back(addr_bus);
        wr_data_q.push_back(data_bus);
        if (bus.ior) pptr++;
      end
    end
    memw_prev = bus.memw;

    if (bus.iow) begin
      iow_len++;
      iow_last = data_bus;
      if (bus.aen != AEN_DMA_D) data_viol++;
    end else if (iow_len > 0) begin
      iow_q.push_back(iow_last);
      iow_len_q.push_back(iow_len);
      iow_len = 0;
    end
    if (bus.tc) begin
      tc_cnt++;
      tc_wr = wr_addr_q.size();
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic configure(input bit dir, input logic [15:0] base, input logic [15:0] count,
                           input bit autoinit);
    bus.cfg_base     = base;
    bus.cfg_count    = count;
    bus.cfg_dir      = dir;
    bus.cfg_autoinit = autoinit;
    bus.cfg_we       = 1'b1;
    tick(1);
    bus.cfg_we       = 1'b0;
  endtask

  task automatic run_xfer(input bit dir, input logic [15:0] base, input logic [15:0] count,
                          input int md, input int iod, input bit rnd);
    int q0, i0, tc0, av0, dv0, k;
    logic [7:0] p0;
    mem_delay = md;
    io_delay  = iod;
    drop_en   = rnd;
    dreq_rand = rnd;
    q0 = wr_addr_q.size(); i0 = iow_q.size(); tc0 = tc_cnt;
    av0 = addr_viol; dv0 = data_viol; p0 = pptr;
    configure(dir, base, count, 1'b0);
    check("busy_set", bus.busy, 1);
    dreq_en = 1'b1;
    k = 0;
    while (bus.busy && k < 4000) begin
      tick(1);
      k++;
    end
    dreq_en = 1'b0;
    check("xfer_done", bus.busy, 0);
    tick(3);
    check("tc_pulses", tc_cnt - tc0, 1);
    check("aen_release", bus.aen, AEN_CPU);
    check("hrq_release", bus.hrq, 0);
    if (dir == DIR_IO2MEM) begin
      check("wr_count", wr_addr_q.size() - q0, count + 1);
      check("tc_after_last", tc_wr - q0, count + 1);
      for (int i = 0; i <= count && q0 + i < wr_addr_q.size(); i++) begin
        check("wr_addr", wr_addr_q[q0 + i], 16'(base + i));
        check("wr_data", wr_data_q[q0 + i], periph[8'(p0 + i)]);
      end
    end else begin
      check("iow_count", iow_q.size() - i0, count + 1);
      check("no_memw", wr_addr_q.size() - q0, 0);
      for (int i = 0; i <= count && i0 + i < iow_q.size(); i++) begin
        check("iow_data", iow_q[i0 + i], rom[16'(base + i)]);
        check("iow_len_ge3", iow_len_q[i0 + i] >= 3, 1);
      end
    end
    check("addr_stable", addr_viol - av0, 0);
    check("data_owner", data_viol - dv0, 0);
    $display("xfer dir=%0d base=%04h count=%0d mwait=%0d iowait=%0d rnd=%0d writes=%0d iows=%0d",
             dir, base, count, md, iod, rnd, wr_addr_q.size() - q0, iow_q.size() - i0);
  endtask

  initial begin
    int q0, i0, tc0, k;
    logic [7:0] p0;
    rst = 1'b1;
    bus.cfg_we = 1'b0; bus.cfg_base = '0; bus.cfg_count = '0;
    bus.cfg_dir = 1'b0; bus.cfg_autoinit = 1'b0;
    for (int i = 0; i < 65536; i++) rom[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) periph[i] = (i < 16) ? 8'(i) : 8'($urandom);
    rom[16'h0200] = 8'hA5;
    rom[16'h0201] = 8'h5A;

    tick(3);
    check("reset_outputs",
          {bus.hrq, bus.dack, bus.ior, bus.iow, bus.memr, bus.memw, bus.tc, bus.busy, bus.aen}, 0);
    rst = 1'b0;
    tick(2);

    run_xfer(DIR_IO2MEM, 16'h0100, 16'd3, 0, 1, 1'b0);
    run_xfer(DIR_MEM2IO, 16'h0200, 16'd1, 0, 1, 1'b0);
    run_xfer(DIR_IO2MEM, 16'hFFFF, 16'd1, 0, 1, 1'b0);
    check("wrap_addr", wr_addr_q[wr_addr_q.size() - 1], 16'h0000);
    run_xfer(DIR_IO2MEM, 16'h0300, 16'd2, 3, 1, 1'b0);

    // Autoinit: single-byte blocks repeat at the same address; a late cfg_we is ignored.
    mem_delay = 0; io_delay = 1; drop_en = 1'b0; dreq_rand = 1'b0;
    q0 = wr_addr_q.size(); i0 = iow_q.size(); tc0 = tc_cnt; p0 = pptr;
    configure(DIR_IO2MEM, 16'h0010, 16'd0, 1'b1);
    dreq_en = 1'b1;
    k = 0;
    while (tc_cnt - tc0 < 2 && k < 500) begin tick(1); k++; end
    configure(DIR_MEM2IO, 16'h0500, 16'd5, 1'b0);
    while (tc_cnt - tc0 < 4 && k < 1000) begin tick(1); k++; end
    check("ai_tc_count", tc_cnt - tc0 >= 4, 1);
    check("ai_busy", bus.busy, 1);
    check("ai_cfg_ignored", iow_q.size() - i0, 0);
    for (int i = q0; i < wr_addr_q.size(); i++) begin
      check("ai_addr", wr_addr_q[i], 16'h0010);
      check("ai_data", wr_data_q[i], periph[8'(p0 + i - q0)]);
    end
    $display("autoinit base=0010 tc=%0d writes=%0d", tc_cnt - tc0, wr_addr_q.size() - q0);
    dreq_en = 1'b0;
    do_reset();
    check("ai_reset_busy", bus.busy, 0);

    // Reset while the memory write is stalled on mem_ready.
    mem_delay = 20;
    q0 = wr_addr_q.size();
    configure(DIR_IO2MEM, 16'h0400, 16'd3, 1'b0);
    dreq_en = 1'b1;
    k = 0;
    while (!bus.memw && k < 200) begin tick(1); k++; end
    check("reached_memw", bus.memw, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_outputs",
          {bus.hrq, bus.dack, bus.ior, bus.iow, bus.memr, bus.memw, bus.tc, bus.busy, bus.aen}, 0);
    dreq_en = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(2);
    check("reset_busy", bus.busy, 0);
    check("reset_no_write", wr_addr_q.size() - q0, 0);
    $display("reset during memw writes=%0d", wr_addr_q.size() - q0);

    for (int t = 0; t < 12; t++) begin
      run_xfer(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom_range(0, 7)),
               $urandom_range(0, 3), $urandom_range(1, 3), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
